// File: rtl/smac_sequencer.sv
// smac_sequencer: control FSM and 4-stage enable pipeline for one bit-serial
// SMAC lane. Beats are accepted over op_valid/op_ready. Each accepted beat is
// tagged with its activation/weight bit position, and the tag rides a valid
// shift chain that produces the per-stage write, clear and sign enables.
module smac_sequencer #(
  parameter int Pa = 8,
  parameter int Pw = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op_valid,
  output logic op_ready,
  output logic we_a,
  output logic we_w,
  output logic we_br,
  output logic MSB_a,
  output logic we_ac1,
  output logic cl_en_ac1,
  output logic we_neg,
  output logic MSB_w,
  output logic we_ac2,
  output logic cl_en_ac2,
  output logic busy,
  output logic done
);

  localparam int IW = $clog2(Pa);
  localparam int JW = $clog2(Pw);
  localparam logic [IW-1:0] I_MAX  = IW'(Pa - 1);
  localparam logic [IW-1:0] I_ZERO = IW'(0);
  localparam logic [IW-1:0] I_ONE  = IW'(1);
  localparam logic [JW-1:0] J_MAX  = JW'(Pw - 1);
  localparam logic [JW-1:0] J_ZERO = JW'(0);
  localparam logic [JW-1:0] J_ONE  = JW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_i;
  logic [JW-1:0] r_j;
  logic          r_op_ready;
  logic          r_busy;
  logic          r_done;

  // Stage 1 (bit register) outputs and the tags it forwards
  logic r_we_br, r_msb_a;
  logic r_t1_i_first, r_t1_i_last, r_t1_j_first, r_t1_j_last;
  // Stage 2 (ac1) outputs and forwarded tags
  logic r_we_ac1, r_cl_en_ac1;
  logic r_t2_i_last, r_t2_j_first, r_t2_j_last;
  // Stage 3 (neg block) outputs and forwarded tag
  logic r_we_neg, r_msb_w;
  logic r_t3_j_first;
  // Stage 4 (ac2) outputs
  logic r_we_ac2, r_cl_en_ac2;

  logic w_accept;
  logic w_i_first;
  logic w_i_last;
  logic w_j_first;
  logic w_j_last;
  logic w_last_beat;
  logic w_chain_busy;

  // r_op_ready is high exactly while in FEED, so a beat is taken on valid & ready.
  assign w_accept     = op_valid & r_op_ready;
  assign w_i_first    = (r_i == I_ZERO);
  assign w_i_last     = (r_i == I_MAX);
  assign w_j_first    = (r_j == J_ZERO);
  assign w_j_last     = (r_j == J_MAX);
  assign w_last_beat  = w_accept & w_i_last & w_j_last;
  // Stage 4 empties by itself; once stages 1-3 are idle the next cycle is clean.
  assign w_chain_busy = r_we_br | r_we_ac1 | r_we_neg;

  // Job FSM with beat counters; busy/done/op_ready are registered with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_i        <= I_ZERO;
      r_j        <= J_ZERO;
      r_op_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FEED;
            r_i        <= I_ZERO;
            r_j        <= J_ZERO;
            r_op_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_FEED: begin
          if (w_accept) begin
            if (w_i_last) begin
              r_i <= I_ZERO;
              if (w_j_last) begin
                r_j <= J_ZERO;
              end else begin
                r_j <= r_j + J_ONE;
              end
            end else begin
              r_i <= r_i + I_ONE;
            end
            if (w_last_beat) begin
              r_state    <= S_DRAIN;
              r_op_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (!w_chain_busy) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_op_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  // Tagged valid shift chain: every flag is gated by its stage valid, so
  // sign and clear flags can never appear without their write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_br      <= 1'b0;
      r_msb_a      <= 1'b0;
      r_t1_i_first <= 1'b0;
      r_t1_i_last  <= 1'b0;
      r_t1_j_first <= 1'b0;
      r_t1_j_last  <= 1'b0;
      r_we_ac1     <= 1'b0;
      r_cl_en_ac1  <= 1'b0;
      r_t2_i_last  <= 1'b0;
      r_t2_j_first <= 1'b0;
      r_t2_j_last  <= 1'b0;
      r_we_neg     <= 1'b0;
      r_msb_w      <= 1'b0;
      r_t3_j_first <= 1'b0;
      r_we_ac2     <= 1'b0;
      r_cl_en_ac2  <= 1'b0;
    end else begin
      // T+1: bit register, sign-negate on the activation MSB
      r_we_br      <= w_accept;
      r_msb_a      <= w_accept & w_i_last;
      r_t1_i_first <= w_accept & w_i_first;
      r_t1_i_last  <= w_accept & w_i_last;
      r_t1_j_first <= w_accept & w_j_first;
      r_t1_j_last  <= w_accept & w_j_last;
      // T+2: ac1 overwrites on the first activation bit of each weight bit
      r_we_ac1     <= r_we_br;
      r_cl_en_ac1  <= r_t1_i_first;
      r_t2_i_last  <= r_t1_i_last;
      r_t2_j_first <= r_t1_i_last & r_t1_j_first;
      r_t2_j_last  <= r_t1_i_last & r_t1_j_last;
      // T+3: neg block captures a finished ac1 sum; negate on the weight MSB
      r_we_neg     <= r_t2_i_last;
      r_msb_w      <= r_t2_i_last & r_t2_j_last;
      r_t3_j_first <= r_t2_i_last & r_t2_j_first;
      // T+4: ac2 overwrites for the first weight bit of the job
      r_we_ac2     <= r_we_neg;
      r_cl_en_ac2  <= r_t3_j_first;
    end
  end

  assign op_ready  = r_op_ready;
  assign we_a      = w_accept;
  assign we_w      = w_accept;
  assign we_br     = r_we_br;
  assign MSB_a     = r_msb_a;
  assign we_ac1    = r_we_ac1;
  assign cl_en_ac1 = r_cl_en_ac1;
  assign we_neg    = r_we_neg;
  assign MSB_w     = r_msb_w;
  assign we_ac2    = r_we_ac2;
  assign cl_en_ac2 = r_cl_en_ac2;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
